// File: rtl/rv_pkg.sv
// Shared RV constants, load funct3 encodings and writeback types.
package rv_pkg;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int RW   = 5;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   typedef enum logic {
      SKID_EMPTY = 1'b0,
      SKID_FULL  = 1'b1
   } skid_state_t;

   // One register-file write: destination plus data.
   typedef struct packed {
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wb_beat_t;

endpackage

// File: rtl/wb_arbiter_ld_ext.sv
// Load data lane select and sign/zero extension (purely combinational).
module ld_ext
   import rv_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      funct3,
   input  logic [2:0]      offset,
   output logic [XLEN-1:0] wdata
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] lane_w;

   // Offset bits below the access size are dropped, so misaligned offsets
   // simply snap down to the containing lane.
   assign lane_b = 8'(rdata >> {offset, 3'b000});
   assign lane_h = 16'(rdata >> {offset[2:1], 4'b0000});
   assign lane_w = 32'(rdata >> {offset[2], 5'b00000});

   // Extend the selected lane; 3'b111 falls through to the full doubleword.
   always_comb begin
      wdata = rdata;
      case (funct3)
         LB:      wdata = {{(XLEN-8){lane_b[7]}}, lane_b};
         LH:      wdata = {{(XLEN-16){lane_h[15]}}, lane_h};
         LW:      wdata = {{(XLEN-32){lane_w[31]}}, lane_w};
         LBU:     wdata = {{(XLEN-8){1'b0}}, lane_b};
         LHU:     wdata = {{(XLEN-16){1'b0}}, lane_h};
         LWU:     wdata = {{(XLEN-32){1'b0}}, lane_w};
         default: wdata = rdata;
      endcase
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load-return streams onto the single
// register-file write port, with a one-entry ALU skid buffer and a
// pending-load scoreboard for decode RAW stalls.
module wb_arbiter #(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_alu_valid,
   output logic            o_alu_ready,
   input  logic [4:0]      i_alu_rd,
   input  logic [XLEN-1:0] i_alu_wdata,
   input  logic            i_ld_issue,
   input  logic [4:0]      i_ld_issue_rd,
   input  logic            i_ld_valid,
   input  logic [4:0]      i_ld_rd,
   input  logic [XLEN-1:0] i_ld_rdata,
   input  logic [2:0]      i_ld_funct3,
   input  logic [2:0]      i_ld_offset,
   output logic            o_wen,
   output logic [4:0]      o_waddr,
   output logic [XLEN-1:0] o_wdata,
   input  logic [4:0]      i_rs1_addr,
   input  logic [4:0]      i_rs2_addr,
   output logic            o_rs1_busy,
   output logic            o_rs2_busy
);

   import rv_pkg::*;

   skid_state_t     state_q, state_d;
   wb_beat_t        skid_q, skid_d, wr_beat;
   logic            wr_vld, wr_en, alu_acc;
   logic [XLEN-1:0] ld_wdata;
   logic [NREG-1:0] busy_q, busy_set, busy_clr;
   logic            issue_conflict;

   ld_ext u_ld_ext (
      .rdata  (i_ld_rdata),
      .funct3 (i_ld_funct3),
      .offset (i_ld_offset),
      .wdata  (ld_wdata)
   );

   // Ready comes straight from the skid state so it never depends on inputs.
   assign o_alu_ready = (state_q == SKID_EMPTY);
   assign alu_acc     = i_alu_valid & o_alu_ready;

   // Source select: load > buffered ALU > direct ALU. An ALU beat accepted
   // alongside a load parks in the skid.
   always_comb begin
      state_d = state_q;
      skid_d  = skid_q;
      wr_vld  = 1'b0;
      wr_beat = '0;
      if (i_ld_valid) begin
         wr_vld       = 1'b1;
         wr_beat.rd   = i_ld_rd;
         wr_beat.data = ld_wdata;
         if (alu_acc) begin
            state_d     = SKID_FULL;
            skid_d.rd   = i_alu_rd;
            skid_d.data = i_alu_wdata;
         end
      end else if (state_q == SKID_FULL) begin
         wr_vld  = 1'b1;
         wr_beat = skid_q;
         state_d = SKID_EMPTY;
      end else if (alu_acc) begin
         wr_vld       = 1'b1;
         wr_beat.rd   = i_alu_rd;
         wr_beat.data = i_alu_wdata;
      end
   end

   // x0 writes are consumed but never reach the register file.
   assign wr_en = wr_vld & (wr_beat.rd != 5'd0);

   // Skid state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= SKID_EMPTY;
      else        state_q <= state_d;
   end

   // Skid payload register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) skid_q <= '0;
      else        skid_q <= skid_d;
   end

   // Register-file write port; address/data hold while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_wen   <= 1'b0;
         o_waddr <= '0;
         o_wdata <= '0;
      end else begin
         o_wen <= wr_en;
         if (wr_en) begin
            o_waddr <= wr_beat.rd;
            o_wdata <= wr_beat.data;
         end
      end
   end

   // Scoreboard set/clear masks; clear lands on the edge the load writes.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (i_ld_issue && (i_ld_issue_rd != 5'd0)) busy_set = NREG'(1) << i_ld_issue_rd;
      if (i_ld_valid)                            busy_clr = NREG'(1) << i_ld_rd;
   end

   // Pending-load bits; a same-cycle set beats the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= (busy_q & ~busy_clr) | busy_set;
   end

   assign o_rs1_busy = busy_q[i_rs1_addr] & (i_rs1_addr != 5'd0);
   assign o_rs2_busy = busy_q[i_rs2_addr] & (i_rs2_addr != 5'd0);

   // Issuing to a register that still has a load in flight is illegal,
   // unless that load is returning on this very edge.
   assign issue_conflict = i_ld_issue && (i_ld_issue_rd != 5'd0) &&
                           busy_q[i_ld_issue_rd] &&
                           !(i_ld_valid && (i_ld_rd == i_ld_issue_rd));

   a_issue_to_busy : assert property (@(posedge clk) disable iff (!rst_n) !issue_conflict);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a queue-based reference model.
module tb_wb_arbiter;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        alu_valid = 0, alu_ready;
   logic [4:0]  alu_rd = 0;
   logic [63:0] alu_wdata = 0;
   logic        ld_issue = 0;
   logic [4:0]  ld_issue_rd = 0;
   logic        ld_valid = 0;
   logic [4:0]  ld_rd = 0;
   logic [63:0] ld_rdata = 0;
   logic [2:0]  ld_funct3 = 0, ld_offset = 0;
   logic        wen;
   logic [4:0]  waddr;
   logic [63:0] wdata;
   logic [4:0]  rs1 = 0, rs2 = 0;
   logic        rs1_busy, rs2_busy;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(64), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_alu_valid(alu_valid), .o_alu_ready(alu_ready),
      .i_alu_rd(alu_rd), .i_alu_wdata(alu_wdata),
      .i_ld_issue(ld_issue), .i_ld_issue_rd(ld_issue_rd),
      .i_ld_valid(ld_valid), .i_ld_rd(ld_rd), .i_ld_rdata(ld_rdata),
      .i_ld_funct3(ld_funct3), .i_ld_offset(ld_offset),
      .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata),
      .i_rs1_addr(rs1), .i_rs2_addr(rs2),
      .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference extension: size from funct3[1:0], lane snapped down to size,
   // sign taken from the top bit of the lane unless funct3[2] says unsigned.
   function automatic logic [63:0] ext_model(logic [63:0] d, logic [2:0] f3, logic [2:0] off);
      int nb = 1 << f3[1:0];
      int base = (int'(off) / nb) * nb;
      logic [63:0] mask;
      logic [63:0] v;
      if (nb == 8) return d;
      mask = (64'd1 << (nb * 8)) - 64'd1;
      v = (d >> (base * 8)) & mask;
      if (!f3[2] && v[nb*8-1]) v = v | ~mask;
      return v;
   endfunction

   // Reference model: ALU beats waiting behind loads sit in a FIFO; the
   // write port shows one beat per cycle.
   typedef struct { logic [4:0] rd; logic [63:0] data; } beat_t;
   beat_t       skq[$];
   logic        mbusy [32];
   logic        m_wen = 0;
   logic [4:0]  m_waddr = 0;
   logic [63:0] m_wdata = 0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         skq.delete();
         foreach (mbusy[i]) mbusy[i] = 1'b0;
         m_wen = 0; m_waddr = 0; m_wdata = 0;
      end else begin
         bit    acc, w;
         beat_t b;
         acc = alu_valid && (skq.size() == 0);
         w = 1'b1;
         if (ld_valid) begin
            b.rd = ld_rd; b.data = ext_model(ld_rdata, ld_funct3, ld_offset);
            if (acc) skq.push_back('{rd: alu_rd, data: alu_wdata});
         end else if (skq.size() > 0) begin
            b = skq.pop_front();
         end else if (acc) begin
            b.rd = alu_rd; b.data = alu_wdata;
         end else begin
            w = 1'b0;
         end
         m_wen = w && (b.rd != 0);
         if (m_wen) begin m_waddr = b.rd; m_wdata = b.data; end
         if (ld_valid) mbusy[ld_rd] = 1'b0;
         if (ld_issue && ld_issue_rd != 0) mbusy[ld_issue_rd] = 1'b1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         check("wen", 64'(wen), 64'(m_wen));
         check("waddr", 64'(waddr), 64'(m_waddr));
         check("wdata", wdata, m_wdata);
         check("ready", 64'(alu_ready), 64'(skq.size() == 0));
         check("rs1_busy", 64'(rs1_busy), 64'(mbusy[rs1] && rs1 != 0));
         check("rs2_busy", 64'(rs2_busy), 64'(mbusy[rs2] && rs2 != 0));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      alu_valid = 0; ld_valid = 0; ld_issue = 0;
   endtask

   localparam logic [63:0] R = 64'h8877665544332211;
   logic [2:0]  ef3  [8] = '{LB, LBU, LH, LWU, LW, LD, LHU, 3'b111};
   logic [2:0]  eoff [8] = '{3'd7, 3'd7, 3'd6, 3'd4, 3'd0, 3'd5, 3'd3, 3'd5};
   logic [63:0] eexp [8] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'hFFFFFFFFFFFF8877,
                             64'h88776655, 64'h44332211, R, 64'h4433, R};

   initial begin
      int k, c;
      bit acc_now;
      // Power-on reset
      #2 rst_n = 0;
      #1;
      check("rst_wen", 64'(wen), 64'd0);
      check("rst_ready", 64'(alu_ready), 64'd1);
      check("rst_wdata", wdata, 64'd0);
      tick(); tick();
      rst_n = 1; chk_en = 1;
      tick();

      // ALU only
      alu_valid = 1; alu_rd = 3; alu_wdata = 64'h1234;
      tick(); idle();
      check("alu_wen", 64'(wen), 64'd1);
      check("alu_waddr", 64'(waddr), 64'd3);
      check("alu_wdata", wdata, 64'h1234);
      alu_valid = 1; alu_rd = 0; alu_wdata = 64'h55;
      tick(); idle();
      check("x0_wen", 64'(wen), 64'd0);
      check("x0_ready", 64'(alu_ready), 64'd1);
      check("x0_hold", wdata, 64'h1234);

      // Collision: load wins, ALU parks in skid, a held beat retires after
      ld_issue = 1; ld_issue_rd = 6;
      tick(); idle();
      alu_valid = 1; alu_rd = 4; alu_wdata = 64'hAA;
      ld_valid = 1; ld_rd = 6; ld_rdata = 64'h600D; ld_funct3 = LD; ld_offset = 0;
      tick(); idle();
      check("col1_waddr", 64'(waddr), 64'd6);
      check("col1_ready", 64'(alu_ready), 64'd0);
      alu_valid = 1; alu_rd = 7; alu_wdata = 64'hBB;
      tick();
      check("col2_waddr", 64'(waddr), 64'd4);
      check("col2_wdata", wdata, 64'hAA);
      check("col2_ready", 64'(alu_ready), 64'd1);
      tick(); idle();
      check("col3_waddr", 64'(waddr), 64'd7);
      check("col3_wdata", wdata, 64'hBB);

      // Load extension
      for (int i = 0; i < 8; i++) begin
         ld_valid = 1; ld_rd = 10; ld_rdata = R; ld_funct3 = ef3[i]; ld_offset = eoff[i];
         tick(); idle();
         check($sformatf("ext%0d", i), wdata, eexp[i]);
         check($sformatf("ext_mdl%0d", i), ext_model(R, ef3[i], eoff[i]), eexp[i]);
      end

      // Scoreboard: set, clear-with-reissue (set wins), clear
      ld_issue = 1; ld_issue_rd = 9; rs2 = 9;
      tick(); idle();
      check("sb_set", 64'(rs2_busy), 64'd1);
      ld_valid = 1; ld_rd = 9; ld_rdata = 64'h99; ld_funct3 = LD;
      ld_issue = 1; ld_issue_rd = 9;
      tick(); idle();
      check("sb_wr_wen", 64'(wen), 64'd1);
      check("sb_wr_addr", 64'(waddr), 64'd9);
      check("sb_setwins", 64'(rs2_busy), 64'd1);
      ld_valid = 1; ld_rd = 9;
      tick(); idle();
      check("sb_clr", 64'(rs2_busy), 64'd0);
      ld_issue = 1; ld_issue_rd = 0; rs1 = 0;
      tick(); idle();
      check("sb_x0", 64'(rs1_busy), 64'd0);

      // Back-to-back loads with a continuous ALU stream
      k = 0; c = 0;
      while (k < 4 && c < 40) begin
         ld_valid = (c < 6); ld_rd = 5'(11 + c); ld_rdata = 64'(c) + 64'hF00; ld_funct3 = LD;
         alu_valid = 1; alu_rd = 5'(20 + k); alu_wdata = 64'h100 + 64'(k);
         acc_now = alu_ready;
         tick();
         if (acc_now) k++;
         if (c < 6) check($sformatf("b2b_stall%0d", c), 64'(alu_ready), 64'd0);
         c++;
      end
      idle();
      if (c >= 40) check("b2b_timeout", 64'(k), 64'd4);
      tick(); tick(); tick();

      // Asynchronous reset mid-stream with skid full and busy[5] set
      ld_issue = 1; ld_issue_rd = 5;
      tick(); idle();
      alu_valid = 1; alu_rd = 8; alu_wdata = 64'h88;
      ld_valid = 1; ld_rd = 12; ld_rdata = 64'h12; ld_funct3 = LD;
      rs1 = 5;
      tick(); idle();
      check("pre_rst_ready", 64'(alu_ready), 64'd0);
      check("pre_rst_busy", 64'(rs1_busy), 64'd1);
      #2 rst_n = 0;
      #1;
      check("mid_rst_wen", 64'(wen), 64'd0);
      check("mid_rst_ready", 64'(alu_ready), 64'd1);
      check("mid_rst_busy", 64'(rs1_busy), 64'd0);
      tick(); tick();
      rst_n = 1;
      alu_valid = 1; alu_rd = 2; alu_wdata = 64'h22;
      tick(); idle();
      check("post_rst_waddr", 64'(waddr), 64'd2);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
